// File: rtl/ed_rx_defs.sv
`default_nettype none
// ============================================================================
// Package  : ed_rx_defs
// Brief    : Shared state encodings, default timing constants and CRC-8 helper
//            for the PIE downlink receiver.
// Revision : 1.0 - initial release
// ============================================================================
package ed_rx_defs;

    localparam int c_filt_len_def   = 3;
    localparam int c_cnt_w_def      = 12;
    localparam int c_pw_max_def     = 60;
    localparam int c_delim_min_def  = 200;
    localparam int c_bit_thresh_def = 300;
    localparam int c_idle_to_def    = 2000;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_delim = 2'd1;
    localparam logic [1:0] c_st_high  = 2'd2;
    localparam logic [1:0] c_st_low   = 2'd3;

    localparam logic [7:0] c_crc_poly = 8'h07;

    // MSB-first CRC-8 update over one byte
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ c_crc_poly) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ed_rx_filter.sv
`default_nettype none
// ============================================================================
// Module   : ed_rx_filter
// Brief    : 2-FF synchroniser, FILT_LEN glitch filter and edge detect for the
//            envelope-detector input.
// Revision : 1.0 - initial release
// ============================================================================
module ed_rx_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_ed,
    output logic o_ed_f,
    output logic o_rise,
    output logic o_fall
);
    localparam int              c_fw   = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [c_fw-1:0] c_last = c_fw'(FILT_LEN - 1);

    logic [1:0]      r_sync;
    logic [c_fw-1:0] r_fcnt;
    logic            r_ed_f;
    logic            r_rise;
    logic            r_fall;

    // A level change is accepted on its FILT_LEN-th consecutive sample
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_fcnt <= '0;
            r_ed_f <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_ed};
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (r_sync[1] == r_ed_f) begin
                r_fcnt <= '0;
            end else if (r_fcnt == c_last) begin
                r_fcnt <= '0;
                r_ed_f <= r_sync[1];
                r_rise <= r_sync[1];
                r_fall <= ~r_sync[1];
            end else begin
                r_fcnt <= r_fcnt + 1'b1;
            end
        end
    end

    assign o_ed_f = r_ed_f;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule
`default_nettype wire

// File: rtl/ed_pie_downlink_rx.sv
`default_nettype none
// ============================================================================
// Module   : ed_pie_downlink_rx
// Brief    : PIE downlink frame decoder (delimiter, bits, bytes, idle end).
//            Define ED_RX_CRC8_EN to enable the CRC-8 frame check.
// Revision : 1.0 - initial release
// ============================================================================
module ed_pie_downlink_rx
    import ed_rx_defs::*;
#(
    parameter int FILT_LEN   = c_filt_len_def,
    parameter int CNT_W      = c_cnt_w_def,
    parameter int PW_MAX     = c_pw_max_def,
    parameter int DELIM_MIN  = c_delim_min_def,
    parameter int BIT_THRESH = c_bit_thresh_def,
    parameter int IDLE_TO    = c_idle_to_def
) (
    input  logic       CLKA,
    input  logic       RSTBTN,
    input  logic       EN,
    input  logic       ED_IN,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    input  logic       RX_READY,
    output logic       RX_SOF,
    output logic       RX_EOF,
    output logic       RX_ERR,
    output logic       CRC_OK
);
    localparam logic [CNT_W-1:0] c_pw_max     = CNT_W'(PW_MAX);
    localparam logic [CNT_W-1:0] c_delim_min  = CNT_W'(DELIM_MIN);
    localparam logic [CNT_W-1:0] c_bit_thresh = CNT_W'(BIT_THRESH);
    localparam logic [CNT_W-1:0] c_idle_to    = CNT_W'(IDLE_TO);

    logic             w_ed_f, w_rise, w_fall;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_state, w_state_nxt;
    logic [6:0]       r_shift;
    logic [7:0]       r_rx_data, w_byte;
    logic [2:0]       r_bitidx;
    logic             r_have_byte, r_valid, r_sof, r_eof, r_err;
    logic             w_bit, w_shift, w_frame_clr, w_byte_done, w_sof, w_eof, w_err;

    ed_rx_filter #(.FILT_LEN(FILT_LEN)) u_filter (
        .clk    (CLKA),
        .rst    (RSTBTN),
        .i_ed   (ED_IN),
        .o_ed_f (w_ed_f),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    always_ff @(posedge CLKA) begin
        if (RSTBTN || w_rise || w_fall) r_cnt <= '0;
        else if (r_cnt != '1)           r_cnt <= r_cnt + 1'b1;
    end

    always_ff @(posedge CLKA) begin
        if (RSTBTN) r_state <= c_st_idle;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift     = 1'b0;
        w_frame_clr = 1'b0;
        w_byte_done = 1'b0;
        w_sof       = 1'b0;
        w_eof       = 1'b0;
        w_err       = 1'b0;
        w_bit       = (r_cnt >= c_bit_thresh);
        w_byte      = {r_shift, w_bit};
        if (!EN) begin
            w_state_nxt = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle: if (w_fall) w_state_nxt = c_st_delim;
                c_st_delim: begin
                    if (w_rise) begin
                        if (r_cnt >= c_delim_min) begin
                            w_state_nxt = c_st_high;
                            w_sof       = 1'b1;
                            w_frame_clr = 1'b1;
                        end else begin
                            w_state_nxt = c_st_idle;
                        end
                    end
                end
                c_st_high: begin
                    if (w_fall) begin
                        w_shift     = 1'b1;
                        w_state_nxt = c_st_low;
                        // A completed byte with the previous one unread aborts the frame
                        if (r_bitidx == 3'd7) begin
                            if (r_valid && !RX_READY) begin
                                w_err       = 1'b1;
                                w_state_nxt = c_st_idle;
                            end else begin
                                w_byte_done = 1'b1;
                            end
                        end
                    end else if (w_ed_f && r_cnt >= c_idle_to) begin
                        w_state_nxt = c_st_idle;
                        if (r_bitidx == 3'd0 && r_have_byte) w_eof = 1'b1;
                        else                                  w_err = 1'b1;
                    end
                end
                default: begin
                    if (w_rise) begin
                        if (r_cnt <= c_pw_max) begin
                            w_state_nxt = c_st_high;
                        end else if (r_cnt >= c_delim_min) begin
                            w_state_nxt = c_st_high;
                            w_sof       = 1'b1;
                            w_frame_clr = 1'b1;
                        end else begin
                            w_state_nxt = c_st_idle;
                            w_err       = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLKA) begin
        if (RSTBTN) begin
            r_shift     <= '0;
            r_bitidx    <= '0;
            r_have_byte <= 1'b0;
            r_rx_data   <= 8'h00;
            r_valid     <= 1'b0;
            r_sof       <= 1'b0;
            r_eof       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_sof <= w_sof;
            r_eof <= w_eof;
            r_err <= w_err;
            if (w_frame_clr) begin
                r_shift     <= '0;
                r_bitidx    <= '0;
                r_have_byte <= 1'b0;
            end else if (w_shift) begin
                r_shift  <= w_byte[6:0];
                r_bitidx <= r_bitidx + 1'b1;
                if (r_bitidx == 3'd7) r_have_byte <= 1'b1;
            end
            if (w_byte_done) begin
                r_rx_data <= w_byte;
                r_valid   <= 1'b1;
            end else if (r_valid && RX_READY) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef ED_RX_CRC8_EN
    logic [7:0] r_crc;
    logic       r_crc_ok;

    always_ff @(posedge CLKA) begin
        if (RSTBTN) begin
            r_crc    <= 8'h00;
            r_crc_ok <= 1'b0;
        end else begin
            r_crc_ok <= w_eof && (r_crc == 8'h00);
            if (w_frame_clr)      r_crc <= 8'h00;
            else if (w_byte_done) r_crc <= crc8_byte(r_crc, w_byte);
        end
    end

    assign CRC_OK = r_crc_ok;
`else
    assign CRC_OK = r_eof;
`endif

    assign RX_DATA  = r_rx_data;
    assign RX_VALID = r_valid;
    assign RX_SOF   = r_sof;
    assign RX_EOF   = r_eof;
    assign RX_ERR   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ed_pie_downlink_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ed_pie_downlink_rx
// Brief    : Randomised and directed frame stimulus for ed_pie_downlink_rx,
//            checked against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ed_pie_downlink_rx;

    localparam int c_idle_hold = 2100;
`ifdef ED_RX_CRC8_EN
    localparam bit c_crc_on = 1'b1;
`else
    localparam bit c_crc_on = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, en, ed_in, rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, rx_sof, rx_eof, rx_err, crc_ok;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_sof, n_eof, n_err, n_stray, n_multi;
    logic       last_crc_ok;
    logic [7:0] got[$];
    logic [7:0] exp_bytes[$];
    logic       tx_bits[$];

    ed_pie_downlink_rx u_dut (
        .CLKA     (clk),
        .RSTBTN   (rst),
        .EN       (en),
        .ED_IN    (ed_in),
        .RX_DATA  (rx_data),
        .RX_VALID (rx_valid),
        .RX_READY (rx_ready),
        .RX_SOF   (rx_sof),
        .RX_EOF   (rx_eof),
        .RX_ERR   (rx_err),
        .CRC_OK   (crc_ok)
    );

    always #5 clk = ~clk;

    // Event monitor: samples just after the falling edge, i.e. the values the next rising edge sees
    always @(negedge clk) begin
        #1;
        if (rx_sof) n_sof++;
        if (rx_err) n_err++;
        if (rx_eof) begin
            n_eof++;
            last_crc_ok = crc_ok;
        end
        if (crc_ok && !rx_eof) n_stray++;
        if (int'(rx_sof) + int'(rx_eof) + int'(rx_err) > 1) n_multi++;
        if (rx_valid && rx_ready) got.push_back(rx_data);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic hold(input logic v, input int n);
        ed_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        @(posedge clk);
        #1;
        n_sof = 0; n_eof = 0; n_err = 0; n_stray = 0; n_multi = 0;
        last_crc_ok = 1'b0;
        got.delete();
        exp_bytes.delete();
        tx_bits.delete();
        @(negedge clk);
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) tx_bits.push_back(b[i]);
    endtask

    // mode 0: random legal timing, 1: fixed 150/400/40, 2: fixed with 2-cycle spikes in 1-bits
    task automatic send_bits(input int mode);
        logic b;
        int   hi, lo;
        while (tx_bits.size() > 0) begin
            b = tx_bits.pop_front();
            if (mode == 0) begin
                hi = b ? int'($urandom_range(320, 400)) : int'($urandom_range(60, 240));
                lo = int'($urandom_range(10, 40));
            end else begin
                hi = b ? 400 : 150;
                lo = 40;
            end
            if (mode == 2 && b) begin
                hold(1'b1, 100); hold(1'b0, 2); hold(1'b1, 100); hold(1'b0, 2); hold(1'b1, 196);
            end else begin
                hold(1'b1, hi);
            end
            hold(1'b0, lo);
        end
    endtask

    // Reference CRC-8 (poly 0x07), bit-serial over the expected byte stream
    function automatic logic [7:0] crc_of_exp();
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        foreach (exp_bytes[i]) begin
            for (int k = 7; k >= 0; k--) begin
                fb = c[7] ^ exp_bytes[i][k];
                c  = {c[6:0], 1'b0};
                if (fb) c = c ^ 8'h07;
            end
        end
        return c;
    endfunction

    function automatic logic exp_crc_ok();
        return c_crc_on ? (crc_of_exp() == 8'h00) : 1'b1;
    endfunction

    task automatic check_frame(input string tag, input int e_sof, input int e_eof,
                               input int e_err, input logic e_crc);
        check_val({tag, ".sof"}, n_sof, e_sof);
        check_val({tag, ".eof"}, n_eof, e_eof);
        check_val({tag, ".err"}, n_err, e_err);
        check_val({tag, ".nbytes"}, got.size(), exp_bytes.size());
        for (int i = 0; i < exp_bytes.size() && i < got.size(); i++)
            check_val($sformatf("%s.byte%0d", tag, i), got[i], exp_bytes[i]);
        if (e_eof > 0) check_val({tag, ".crc_ok"}, last_crc_ok, e_crc);
        check_val({tag, ".crc_stray"}, n_stray, 0);
        check_val({tag, ".multi"}, n_multi, 0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; ed_in = 1'b1; rx_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            ed_in = ~ed_in;
            @(negedge clk);
            check_val("reset.outs", {rx_data, rx_valid, rx_sof, rx_eof, rx_err, crc_ok}, 0);
        end
        rst = 1'b0;
        hold(1'b1, 50);

        // Directed 0xA5 frame
        clear_mon();
        exp_bytes.push_back(8'hA5);
        push_byte(8'hA5);
        hold(1'b0, 250); send_bits(1); hold(1'b1, 2500);
        check_frame("a5", 1, 1, 0, exp_crc_ok());

        // Glitches inside 1-bit highs
        clear_mon();
        exp_bytes.push_back(8'hC3);
        push_byte(8'hC3);
        hold(1'b0, 250); send_bits(2); hold(1'b1, c_idle_hold);
        check_frame("glitch", 1, 1, 0, exp_crc_ok());

        // 120-cycle low mid-frame
        clear_mon();
        for (int i = 0; i < 4; i++) tx_bits.push_back(1'(i & 1));
        hold(1'b0, 250); send_bits(1); hold(1'b1, 150); hold(1'b0, 120); hold(1'b1, c_idle_hold);
        check_frame("badlow", 1, 0, 1, 1'b0);

        // Overflow with consumer stalled
        clear_mon();
        rx_ready = 1'b0;
        push_byte(8'h12); push_byte(8'h34);
        hold(1'b0, 250); send_bits(0); hold(1'b1, c_idle_hold);
        check_frame("ovf", 1, 0, 1, 1'b0);
        check_val("ovf.data", rx_data, 8'h12);
        check_val("ovf.valid", rx_valid, 1'b1);
        rx_ready = 1'b1;
        hold(1'b1, 4);
        check_val("ovf.npop", got.size(), 1);
        check_val("ovf.pop", (got.size() > 0) ? {1'b0, got[0]} : 9'h100, 9'h012);
        check_val("ovf.valid_clr", rx_valid, 1'b0);

        // CRC directed frames
        clear_mon();
        exp_bytes.push_back(8'h01); exp_bytes.push_back(8'h07);
        push_byte(8'h01); push_byte(8'h07);
        hold(1'b0, 250); send_bits(0); hold(1'b1, c_idle_hold);
        check_frame("crc_good", 1, 1, 0, 1'b1);
        clear_mon();
        exp_bytes.push_back(8'h01); exp_bytes.push_back(8'h08);
        push_byte(8'h01); push_byte(8'h08);
        hold(1'b0, 250); send_bits(0); hold(1'b1, c_idle_hold);
        check_frame("crc_bad", 1, 1, 0, c_crc_on ? 1'b0 : 1'b1);

        // EN dropped mid-frame
        clear_mon();
        for (int i = 0; i < 3; i++) tx_bits.push_back(1'b1);
        hold(1'b0, 250); send_bits(0); hold(1'b1, 50);
        en = 1'b0; hold(1'b1, 20); en = 1'b1;
        hold(1'b1, c_idle_hold);
        check_frame("en_drop", 1, 0, 0, 1'b0);

        // Long low mid-frame restarts the frame
        clear_mon();
        for (int i = 0; i < 3; i++) tx_bits.push_back(1'b0);
        hold(1'b0, 250); send_bits(0); hold(1'b0, 250);
        exp_bytes.push_back(8'h5A);
        push_byte(8'h5A);
        send_bits(0); hold(1'b1, c_idle_hold);
        check_frame("restart", 2, 1, 0, exp_crc_ok());

        // Too-short delimiter is not a frame
        clear_mon();
        push_byte(8'hFF);
        hold(1'b0, 150); send_bits(0); hold(1'b1, c_idle_hold);
        check_frame("shortdelim", 0, 0, 0, 1'b0);

        // Randomised frames, some with a trailing partial byte
        for (int f = 0; f < 3; f++) begin
            int nb, extra;
            clear_mon();
            nb = int'($urandom_range(1, 2));
            for (int i = 0; i < nb; i++) exp_bytes.push_back(8'($urandom_range(0, 255)));
            if (c_crc_on && $urandom_range(0, 1) == 1) exp_bytes.push_back(crc_of_exp());
            foreach (exp_bytes[i]) push_byte(exp_bytes[i]);
            extra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
            for (int i = 0; i < extra; i++) tx_bits.push_back(1'($urandom_range(0, 1)));
            hold(1'b0, int'($urandom_range(210, 400)));
            send_bits(0);
            hold(1'b1, c_idle_hold);
            if (extra == 0) check_frame($sformatf("rnd%0d", f), 1, 1, 0, exp_crc_ok());
            else            check_frame($sformatf("rnd%0d", f), 1, 0, 1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
